// File: rtl/if_stage_pkg.sv
// Shared pipeline types: IF/ID bundle, bubble value and fetch FSM states.
package if_stage_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   function automatic if_id_t bubble_of(input logic [31:0] nop);
      if_id_t b;
      b.instr = nop;
      b.pc4   = 32'h0000_0000;
      b.valid = 1'b0;
      return b;
   endfunction

   localparam if_id_t IF_ID_BUBBLE = bubble_of(NOP_WORD);

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; neither asserted holds contents.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter if_id_t BUBBLE = IF_ID_BUBBLE
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= BUBBLE;
      else if (bubble)
         q <= BUBBLE;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, RUN/HALT FSM, IF/ID capture, fetch counter.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT = 32'd60,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc4;
   logic         in_range;
   logic         fetch_ok;
   logic         ifid_load;
   logic         ifid_bubble;
   if_id_t       ifid_d;
   if_id_t       ifid_q;

   assign imem_addr = pc;
   assign pc4       = pc + 32'd4;
   assign in_range  = (pc < PC_LIMIT);
   // a real fetch retires only in RUN, inside the program, with no stall or squash
   assign fetch_ok  = !redirect && !stall && (state == RUN) && in_range;

   always_comb begin
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      if (redirect)
         ifid_bubble = 1'b1;
      else if (!stall) begin
         if (fetch_ok)
            ifid_load = 1'b1;
         else
            ifid_bubble = 1'b1;
      end
   end

   always_comb begin
      ifid_d.instr = imem_data;
      ifid_d.pc4   = pc4;
      ifid_d.valid = 1'b1;
   end

   // PC, FSM and retired-fetch counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         fetch_count <= 32'd0;
      end else if (redirect) begin
         pc    <= redirect_pc;
         state <= (redirect_pc < PC_LIMIT) ? RUN : HALT;
      end else if (!stall) begin
         case (state)
            RUN: begin
               if (in_range) begin
                  pc          <= pc4;
                  fetch_count <= fetch_count + 32'd1;
               end else begin
                  state <= HALT;
               end
            end
            HALT: state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

   // IF/ID boundary
   if_id_reg #(
      .BUBBLE (bubble_of(NOP_WORD))
   ) u_if_id_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ifid_load),
      .bubble (ifid_bubble),
      .d      (ifid_d),
      .q      (ifid_q)
   );

   assign if_id_instr = ifid_q.instr;
   assign if_id_pc4   = ifid_q.pc4;
   assign if_id_valid = ifid_q.valid;
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a 15-word ROM holding 0x1000_0000+k at word k.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   if_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_data = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

   function automatic logic [31:0] word(input int k);
      return 32'h1000_0000 + k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input logic [31:0] cnt);
      chk({tag, ".pc"}, imem_addr, pc);
      chk({tag, ".instr"}, if_id_instr, ins);
      chk({tag, ".pc4"}, if_id_pc4, p4);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
      chk({tag, ".count"}, fetch_count, cnt);
   endtask

   initial begin
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      #1;
      chk_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      chk("reset.halted", {31'd0, halted}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      chk("release.pc", imem_addr, 32'd0);

      // sequential fetch of the whole program
      for (int k = 1; k <= 15; k++) begin
         step();
         chk_ifid("seq", 4 * k, word(k - 1), 4 * k, 1'b1, k);
      end
      step();
      chk("end.halted", {31'd0, halted}, 32'd1);
      chk_ifid("end", 32'd60, 32'd0, 32'd0, 1'b0, 32'd15);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("idle.pc", imem_addr, 32'd60);
         chk("idle.count", fetch_count, 32'd15);
         chk("idle.halted", {31'd0, halted}, 32'd1);
      end

      // restart from halt
      redirect = 1'b1; redirect_pc = 32'd0;
      step();
      chk("restart.halted", {31'd0, halted}, 32'd0);
      chk_ifid("restart", 32'd0, 32'd0, 32'd0, 1'b0, 32'd15);
      redirect = 1'b0;
      step();
      chk_ifid("rs1", 32'd4, word(0), 32'd4, 1'b1, 32'd16);
      step();
      chk_ifid("rs2", 32'd8, word(1), 32'd8, 1'b1, 32'd17);

      // stall at pc=8
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_ifid("stall", 32'd8, word(1), 32'd8, 1'b1, 32'd17);
      end
      stall = 1'b0;
      step();
      chk_ifid("resume0", 32'd12, word(2), 32'd12, 1'b1, 32'd18);
      step();
      chk_ifid("resume1", 32'd16, word(3), 32'd16, 1'b1, 32'd19);
      step();
      chk_ifid("resume2", 32'h14, word(4), 32'h14, 1'b1, 32'd20);

      // branch redirect at pc=0x14
      redirect = 1'b1; redirect_pc = 32'h24;
      step();
      chk_ifid("br.bubble", 32'h24, 32'd0, 32'd0, 1'b0, 32'd20);
      redirect = 1'b0;
      step();
      chk_ifid("br.target", 32'h28, word(9), 32'h28, 1'b1, 32'd21);

      // redirect overrides stall
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h8;
      step();
      chk_ifid("rdst", 32'h8, 32'd0, 32'd0, 1'b0, 32'd21);
      redirect = 1'b0; stall = 1'b0;
      step();
      chk_ifid("rdst.next", 32'd12, word(2), 32'd12, 1'b1, 32'd22);

      // jump to last word, run into halt
      redirect = 1'b1; redirect_pc = 32'h38;
      step();
      redirect = 1'b0;
      step();
      chk_ifid("last", 32'h3C, word(14), 32'h3C, 1'b1, 32'd23);
      step();
      chk("last.halted", {31'd0, halted}, 32'd1);

      // redirect beyond program while halted stays halted
      redirect = 1'b1; redirect_pc = 32'h40;
      step();
      chk("oob.halted", {31'd0, halted}, 32'd1);
      chk_ifid("oob", 32'h40, 32'd0, 32'd0, 1'b0, 32'd23);
      redirect = 1'b0;
      step();
      chk("oob2.halted", {31'd0, halted}, 32'd1);
      chk("oob2.pc", imem_addr, 32'h40);

      redirect = 1'b1; redirect_pc = 32'h0;
      step();
      chk("back.halted", {31'd0, halted}, 32'd0);
      redirect = 1'b0;
      for (int k = 1; k <= 7; k++) step();
      chk_ifid("to1c", 32'h1C, word(6), 32'h1C, 1'b1, 32'd30);

      // async reset in the middle of a stall
      stall = 1'b1;
      step();
      chk("prerst.pc", imem_addr, 32'h1C);
      #2 rst_n = 1'b0;
      #1;
      chk_ifid("async", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      chk("async.halted", {31'd0, halted}, 32'd0);
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rel2.pc", imem_addr, 32'd0);
      step();
      chk_ifid("rel2", 32'd4, word(0), 32'd4, 1'b1, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
